accum_bank: RTL and testbench

ACCUM_BANK -- requirements
Module: accum_bank

---
 rtl/accum_bank.sv | 98 +++++++++
 tb/tb_accum_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : accum_bank
// Purpose  : Bank of NUM_CH accumulators with load/add/inc/clear commands,
//            sticky per-channel overflow, zero flags and a registered read port.
// Revision : 1.0
// ============================================================================
module accum_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int SAT_EN     = 0,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  we,
  input  logic                  add,
  input  logic                  inc,
  input  logic                  clr,
  input  logic                  clr_all,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CH_W-1:0]       rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]     z,
  output logic [NUM_CH-1:0]     ovf
);

  localparam logic SAT = (SAT_EN != 0);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_d;
  logic [NUM_CH-1:0]                 ovf_d;
  logic [NUM_CH-1:0]                 z_d;
  logic [DATA_WIDTH-1:0]             rd_d;
  logic [DATA_WIDTH-1:0]             sel_val;
  logic [DATA_WIDTH-1:0]             addend;
  logic [DATA_WIDTH-1:0]             acc_val;
  logic [DATA_WIDTH:0]               sum;

  // Single shared adder: only the selected channel can add/inc in a cycle.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) sel_val = ch_q[i];
    end
    addend  = add ? data_in : DATA_WIDTH'(1);
    sum     = {1'b0, sel_val} + {1'b0, addend};
    acc_val = (sum[DATA_WIDTH] && SAT) ? '1 : sum[DATA_WIDTH-1:0];
  end

  // Out-of-range ch_sel matches no channel, so it updates nothing.
  always_comb begin
    ch_d  = ch_q;
    ovf_d = ovf;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr_all) begin
        ch_d[i]  = '0;
        ovf_d[i] = 1'b0;
      end else if (ch_sel == CH_W'(i)) begin
        if (we) begin
          ch_d[i]  = data_in;
          ovf_d[i] = 1'b0;
        end else if (add || inc) begin
          ch_d[i] = acc_val;
          if (sum[DATA_WIDTH]) ovf_d[i] = 1'b1;
        end else if (clr) begin
          ch_d[i]  = '0;
          ovf_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      z_d[i] = (ch_d[i] == '0);
      if (rd_sel == CH_W'(i)) rd_d = ch_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      ovf     <= '0;
      z       <= '1;
      rd_data <= '0;
    end else begin
      ch_q    <= ch_d;
      ovf     <= ovf_d;
      z       <= z_d;
      rd_data <= rd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_bank
// Purpose  : Directed bench for accum_bank: wrapping 4-channel build and a
//            saturating 5-channel build (exercises out-of-range selects).
// Revision : 1.0
// ============================================================================
module tb_accum_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_sel, rd_sel;
  logic [2:0]  ch_sel_s, rd_sel_s;
  logic        we, add, inc, clr, clr_all;
  logic [15:0] data_in;
  logic [15:0] rd_w, rd_s;
  logic [3:0]  z_w, ovf_w;
  logic [4:0]  z_s, ovf_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  accum_bank #(.DATA_WIDTH(16), .NUM_CH(4), .SAT_EN(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel), .we(we), .add(add), .inc(inc),
    .clr(clr), .clr_all(clr_all), .data_in(data_in), .rd_sel(rd_sel),
    .rd_data(rd_w), .z(z_w), .ovf(ovf_w)
  );

  accum_bank #(.DATA_WIDTH(16), .NUM_CH(5), .SAT_EN(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel_s), .we(we), .add(add), .inc(inc),
    .clr(clr), .clr_all(clr_all), .data_in(data_in), .rd_sel(rd_sel_s),
    .rd_data(rd_s), .z(z_s), .ovf(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmds();
    we = 0; add = 0; inc = 0; clr = 0; clr_all = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1; idle_cmds();
    ch_sel = 0; rd_sel = 0; ch_sel_s = 0; rd_sel_s = 0; data_in = 0;
    tick(); tick();

    // Asynchronous reset between edges
    rst_n = 0; #1;
    chk("rst_rd",    32'(rd_w),  32'h0);
    chk("rst_z",     32'(z_w),   32'hF);
    chk("rst_ovf",   32'(ovf_w), 32'h0);
    chk("rst_z_s",   32'(z_s),   32'h1F);
    rst_n = 1;
    tick(); tick(); tick();
    chk("idle_rd",   32'(rd_w),  32'h0);
    chk("idle_z",    32'(z_w),   32'hF);
    chk("idle_ovf",  32'(ovf_w), 32'h0);

    // Priority: we beats add/inc/clr
    ch_sel = 2; rd_sel = 2; data_in = 16'h1234;
    we = 1; add = 1; inc = 1; clr = 1;
    tick();
    chk("prio_z",    32'(z_w),   32'hB);
    chk("prio_rd_old", 32'(rd_w), 32'h0);
    idle_cmds();
    tick();
    chk("prio_rd_new", 32'(rd_w), 32'h1234);

    // clr_all beats everything
    we = 1; add = 1; inc = 1; clr = 1; clr_all = 1;
    tick();
    chk("clrall_z",  32'(z_w),   32'hF);
    idle_cmds();
    tick();
    chk("clrall_rd", 32'(rd_w),  32'h0);

    // Wrap on ch1
    ch_sel = 1; rd_sel = 1; data_in = 16'hFFFE; we = 1;
    tick();
    we = 0; inc = 1;
    tick();
    chk("wrap_rd0",  32'(rd_w),  32'hFFFE);
    chk("wrap_z0",   32'(z_w),   32'hD);
    chk("wrap_ovf0", 32'(ovf_w), 32'h0);
    tick();
    chk("wrap_rd1",  32'(rd_w),  32'hFFFF);
    chk("wrap_z1",   32'(z_w),   32'hF);
    chk("wrap_ovf1", 32'(ovf_w), 32'h2);
    inc = 0;
    tick();
    chk("wrap_rd2",  32'(rd_w),  32'h0);
    chk("wrap_sticky", 32'(ovf_w), 32'h2);
    clr = 1;
    tick();
    chk("wrap_clr_ovf", 32'(ovf_w), 32'h0);
    clr = 0;

    // Accumulate ch2 by 3, then add beats inc/clr
    ch_sel = 2; rd_sel = 2; clr = 1;
    tick();
    clr = 0; add = 1; data_in = 16'd3;
    tick(); chk("acc_rd0", 32'(rd_w), 32'd0);
    tick(); chk("acc_rd3", 32'(rd_w), 32'd3);
    tick(); chk("acc_rd6", 32'(rd_w), 32'd6);
    tick(); chk("acc_rd9", 32'(rd_w), 32'd9);
    add = 0;
    tick(); chk("acc_rd12", 32'(rd_w), 32'd12);
    chk("acc_z",   32'(z_w),   32'hB);
    chk("acc_ovf", 32'(ovf_w), 32'h0);
    add = 1; inc = 1; clr = 1; data_in = 16'd1;
    tick();
    idle_cmds();
    tick(); chk("add_prio_rd", 32'(rd_w), 32'd13);

    // Isolation and read latency on ch3
    ch_sel = 3; rd_sel = 3; data_in = 16'h00AA; we = 1;
    tick(); chk("iso_rd_old", 32'(rd_w), 32'h0);
    we = 0;
    tick(); chk("iso_rd_new", 32'(rd_w), 32'h00AA);
    rd_sel = 0; tick(); chk("iso_ch0", 32'(rd_w), 32'h0);
    rd_sel = 1; tick(); chk("iso_ch1", 32'(rd_w), 32'h0);
    rd_sel = 2; tick(); chk("iso_ch2", 32'(rd_w), 32'd13);
    chk("iso_z", 32'(z_w), 32'h3);

    // Saturation on the 5-channel build
    clr_all = 1;
    tick();
    clr_all = 0;
    ch_sel_s = 0; rd_sel_s = 0; data_in = 16'hFF00; we = 1;
    tick();
    we = 0; add = 1; data_in = 16'h0200;
    tick();
    chk("sat_rd_old", 32'(rd_s),  32'hFF00);
    chk("sat_ovf0",   32'(ovf_s), 32'h01);
    data_in = 16'h0001;
    tick();
    chk("sat_rd1",    32'(rd_s),  32'hFFFF);
    chk("sat_ovf1",   32'(ovf_s), 32'h01);
    add = 0;
    tick();
    chk("sat_rd2",    32'(rd_s),  32'hFFFF);

    // Out-of-range selects
    rd_sel_s = 5; tick(); chk("oor_rd5", 32'(rd_s), 32'h0);
    rd_sel_s = 7; tick(); chk("oor_rd7", 32'(rd_s), 32'h0);
    ch_sel_s = 5; data_in = 16'h1111; we = 1;
    tick();
    we = 0;
    chk("oor_z",   32'(z_s),   32'h1E);
    chk("oor_ovf", 32'(ovf_s), 32'h01);
    rd_sel_s = 0; tick(); chk("oor_ch0", 32'(rd_s), 32'hFFFF);

    // Reset mid-command, first command taken on first edge after release
    ch_sel = 1; rd_sel = 1; data_in = 16'h0055; we = 1;
    rst_n = 0; #1;
    chk("rst2_rd", 32'(rd_w), 32'h0);
    chk("rst2_z",  32'(z_w),  32'hF);
    chk("rst2_ovf_s", 32'(ovf_s), 32'h0);
    rst_n = 1;
    tick();
    chk("rst2_first_z", 32'(z_w), 32'hD);
    we = 0;
    tick();
    chk("rst2_first_rd", 32'(rd_w), 32'h0055);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
